// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHold,
        StRun,
        StDone
    } boot_state_e;

    localparam int unsigned WORD_STRIDE       = 4;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned DEFAULT_MAX_WORDS = 64;

endpackage

// File: rtl/boot_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module boot_down_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/imem_boot_sequencer.sv
// Streams a program into CPU instruction memory, then clears, runs and halts the CPU
// for a programmed number of cycles.
module imem_boot_sequencer
    import imem_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int unsigned MAX_WORDS  = DEFAULT_MAX_WORDS,
    parameter int unsigned CNT_W      = 7,
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned RUN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [31:0]      load_data,
    input  logic             load_last,
    output logic             cpu_init,
    output logic [31:0]      cpu_init_addr,
    output logic [31:0]      cpu_init_data,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] words_loaded
);

    boot_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [RUN_W-1:0] budget_q;
    logic             cpu_init_q, cpu_rst_q, done_q, overflow_q;
    logic [31:0]      addr_q, data_q;

    logic             handshake, write_en, start_ok, at_limit;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [RUN_W-1:0] cnt_value;

    assign load_ready = (state_q == StLoad);
    assign busy       = !((state_q == StIdle) || (state_q == StDone));
    assign handshake  = load_valid && load_ready;
    assign write_en   = handshake && !abort;
    assign start_ok   = start && !abort && ((state_q == StIdle) || (state_q == StDone));
    assign count_next = count_q + 1'b1;
    assign at_limit   = (count_next == CNT_W'(MAX_WORDS));

    // One counter times both phases: reloaded with the hold length on HOLD entry and
    // with the run budget on RUN entry.
    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_value = '0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (handshake && (load_last || at_limit)) begin
                    state_d   = StHold;
                    cnt_load  = 1'b1;
                    cnt_value = RUN_W'(RESET_HOLD - 1);
                end
            end
            StHold: begin
                if (cnt_zero) begin
                    state_d   = StRun;
                    cnt_load  = 1'b1;
                    cnt_value = budget_q - 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StRun: begin
                // A zero budget means free-running until abort.
                if (budget_q != '0) begin
                    if (cnt_zero) state_d = StDone;
                    else          cnt_dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    boot_down_counter #(
        .WIDTH (RUN_W)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            budget_q   <= '0;
            cpu_init_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_init_q <= write_en;
            cpu_rst_q  <= (state_d != StRun);
            done_q     <= (state_d == StDone);
            if (start_ok) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
                budget_q   <= run_cycles;
            end else if (write_en) begin
                count_q <= count_next;
                addr_q  <= BASE_ADDR + 32'(WORD_STRIDE) * 32'(count_q);
                data_q  <= load_data;
                if (at_limit && !load_last) overflow_q <= 1'b1;
            end
        end
    end

    assign cpu_init      = cpu_init_q;
    assign cpu_init_addr = addr_q;
    assign cpu_init_data = data_q;
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign words_loaded  = count_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Randomized self-checking bench for imem_boot_sequencer against a transaction-level
// model of the expected writes and reset/run timing.
module tb_imem_boot_sequencer;

    localparam int unsigned MAXW  = 4;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned RH    = 2;
    localparam int unsigned RUN_W = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [RUN_W-1:0] run_cycles = '0;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [31:0]      load_data = '0;
    logic             load_last = 1'b0;
    logic             cpu_init;
    logic [31:0]      cpu_init_addr;
    logic [31:0]      cpu_init_data;
    logic             cpu_rst;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] words_loaded;

    imem_boot_sequencer #(
        .BASE_ADDR  (BASE),
        .MAX_WORDS  (MAXW),
        .CNT_W      (CNT_W),
        .RESET_HOLD (RH),
        .RUN_W      (RUN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .run_cycles    (run_cycles),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .cpu_init      (cpu_init),
        .cpu_init_addr (cpu_init_addr),
        .cpu_init_data (cpu_init_data),
        .cpu_rst       (cpu_rst),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned init_without_rst = 0;

    typedef struct {
        int unsigned c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    int unsigned hs_c[$];
    logic [31:0] src_words[$];
    logic [31:0] exp_words[$];
    bit          rst_tr[int unsigned];
    bit          done_tr[int unsigned];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cpu_init) wr_q.push_back('{c: cyc, a: cpu_init_addr, d: cpu_init_data});
        if (load_valid && load_ready) hs_c.push_back(cyc);
        if (cpu_init && !cpu_rst) init_without_rst++;
        rst_tr[cyc]  = cpu_rst;
        done_tr[cyc] = done;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_flags"}, {cpu_rst, cpu_init, load_ready, busy, done, overflow}, 6'b100000);
        check_eq({tag, "_count"}, words_loaded, 0);
        check_eq({tag, "_addr"}, cpu_init_addr, 0);
        check_eq({tag, "_data"}, cpu_init_data, 0);
    endtask

    // Offers each word of src_words; a word never seen with load_ready is refused.
    task automatic send_words(input bit with_last, input int gap, output int acc);
        bit got;
        acc = 0;
        for (int i = 0; i < src_words.size(); i++) begin
            if (i > 0) begin
                start = (gap > 0);
                repeat (gap) step();
                start = 1'b0;
            end
            load_valid = 1'b1;
            load_data  = src_words[i];
            load_last  = with_last && (i == src_words.size() - 1);
            got = 1'b0;
            for (int t = 0; t < 4 && !got; t++) begin
                @(negedge clk);
                got = load_ready;
                step();
            end
            load_valid = 1'b0;
            load_last  = 1'b0;
            load_data  = $urandom;
            if (got) begin
                acc++;
                exp_words.push_back(src_words[i]);
            end
        end
    endtask

    task automatic begin_load(input int rc);
        wr_q.delete();
        hs_c.delete();
        exp_words.delete();
        run_cycles = RUN_W'(rc);
        start = 1'b1;
        step();
        start = 1'b0;
        run_cycles = RUN_W'($urandom);
    endtask

    task automatic check_writes(input string nm, input int n);
        check_eq({nm, "_writes"}, wr_q.size(), n);
        for (int k = 0; k < wr_q.size() && k < exp_words.size() && k < hs_c.size(); k++) begin
            check_eq({nm, "_addr"}, wr_q[k].a, BASE + 32'(4 * k));
            check_eq({nm, "_data"}, wr_q[k].d, exp_words[k]);
            check_eq({nm, "_wr_latency"}, wr_q[k].c, hs_c[k] + 1);
        end
    endtask

    task automatic scenario(input string nm, input bit with_last, input int gap, input int rc);
        int acc, exp_acc, t, hi, lo;
        int unsigned c;
        begin_load(rc);
        @(negedge clk);
        check_eq({nm, "_start_flags"}, {busy, load_ready, done, overflow}, 4'b1100);
        check_eq({nm, "_start_count"}, words_loaded, 0);
        step();
        send_words(with_last, gap, acc);
        exp_acc = with_last ? src_words.size() : MAXW;
        check_eq({nm, "_accepted"}, acc, exp_acc);
        check_eq({nm, "_handshakes"}, hs_c.size(), exp_acc);
        t = 0;
        while (done !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        #1;
        check_eq({nm, "_done"}, done, 1);
        check_writes(nm, exp_acc);
        if (hs_c.size() > 0) begin
            c  = hs_c[hs_c.size() - 1] + 1;
            hi = 0;
            lo = 0;
            while (rst_tr.exists(c) && rst_tr[c] && hi < 100) begin
                hi++;
                c++;
            end
            while (rst_tr.exists(c) && !rst_tr[c] && lo < 400) begin
                lo++;
                c++;
            end
            check_eq({nm, "_hold_cycles"}, hi, RH);
            check_eq({nm, "_run_cycles"}, lo, rc);
            check_eq({nm, "_done_at_halt"}, done_tr.exists(c) ? done_tr[c] : 1'b0, 1);
        end
        check_eq({nm, "_overflow"}, overflow, !with_last);
        check_eq({nm, "_words_loaded"}, words_loaded, exp_acc);
        repeat (3) @(negedge clk);
        check_eq({nm, "_done_held"}, {done, cpu_rst, busy}, 3'b110);
    endtask

    initial begin
        int acc, cnt, n;
        bit wl;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst = 1'b1;

        // start and abort together: abort wins
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_idle", {busy, load_ready}, 2'b00);

        // Directed program, back-to-back
        src_words = {32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
        scenario("basic", 1'b1, 0, 10);

        // Two idle cycles between words (start pulsed in the gaps)
        src_words = {$urandom, $urandom, $urandom};
        scenario("gaps", 1'b1, 2, 4);

        // Capacity reached without last; fifth word must be refused
        src_words = {$urandom, $urandom, $urandom, $urandom, $urandom};
        scenario("ovf", 1'b0, 0, 6);

        // Randomized programs
        for (int r = 0; r < 8; r++) begin
            wl = ($urandom_range(3, 0) != 0);
            n  = wl ? $urandom_range(MAXW, 1) : MAXW + 1;
            src_words.delete();
            for (int i = 0; i < n; i++) src_words.push_back($urandom);
            scenario("rand", wl, $urandom_range(2, 0), $urandom_range(12, 1));
        end

        // Abort mid-load, then reload from the base address
        src_words = {$urandom, $urandom};
        begin_load(8);
        send_words(1'b0, 0, acc);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_flags", {load_ready, cpu_init, cpu_rst, busy, done}, 5'b00100);
        check_eq("abort_words_loaded", words_loaded, 2);
        check_writes("abort", 2);
        step();
        src_words = {$urandom, $urandom, $urandom};
        scenario("reload", 1'b1, 0, 3);

        // Zero budget runs until abort
        src_words = {$urandom};
        begin_load(0);
        send_words(1'b1, 0, acc);
        repeat (RH + 1) step();
        cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cpu_rst || done || !busy) cnt++;
        end
        check_eq("zero_budget_running", cnt, 0);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check_eq("zero_budget_abort", {cpu_rst, done, busy}, 3'b100);

        // Asynchronous reset in the middle of a run
        src_words = {$urandom, $urandom};
        begin_load(40);
        send_words(1'b1, 0, acc);
        repeat (6) step();
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("after_reset");

        check_eq("init_implies_rst", init_without_rst, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
